// File: rtl/k051962_tile_fetcher.sv
// Tile fetch sequencer: per 8-pixel group, reads tilemap word + planar ROM row for FIX, A and B
// layers in fixed 8-tick slots and presents each row to the pixel serializer with a strobe.
module k051962_tile_fetcher #(
   parameter int          SLOT_TICKS = 8,
   parameter int          HGROUPS    = 48,
   parameter logic [31:0] MISS_FILL  = 32'h0
) (
   input  logic        clk_24M,
   input  logic        RES,
   input  logic        line_start,
   input  logic [7:0]  vpos,
   input  logic [8:0]  scrollx_a,
   input  logic [8:0]  scrollx_b,
   input  logic [7:0]  scrolly_a,
   input  logic [7:0]  scrolly_b,
   output logic        map_rd,
   output logic [12:0] map_addr,
   input  logic [15:0] map_data,
   output logic        rom_req,
   output logic [13:0] rom_addr,
   input  logic        rom_ack,
   input  logic [31:0] rom_data,
   output logic [31:0] VC,
   output logic [7:0]  COL,
   output logic        vc_valid,
   output logic [1:0]  vc_layer,
   output logic        ZA1H,
   output logic        ZA2H,
   output logic        ZA4H,
   output logic        ZB1H,
   output logic        ZB2H,
   output logic        ZB4H,
   output logic [7:0]  miss_cnt
);

   localparam logic [4:0] LAST_TICK  = 5'(4 * SLOT_TICKS - 1);
   localparam logic [5:0] LAST_GROUP = 6'(HGROUPS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MAP_RD,
      S_MAP_LATCH,
      S_ROM_WAIT,
      S_PRESENT,
      S_GAP
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [4:0]  r_tick;
   logic [4:0]  w_tick_next;
   logic [5:0]  r_group;
   logic [5:0]  w_group_next;

   logic [7:0]  r_vpos;
   logic [8:0]  r_sxa;
   logic [8:0]  r_sxb;
   logic [7:0]  r_sya;
   logic [7:0]  r_syb;
   logic [2:0]  r_za;
   logic [2:0]  r_zb;

   logic        r_rom_req;
   logic [13:0] r_rom_addr;
   logic        r_hit;
   logic [31:0] r_rom_buf;
   logic [7:0]  r_col_pend;
   logic [31:0] r_vc;
   logic [7:0]  r_col;
   logic [1:0]  r_vc_layer;
   logic [7:0]  r_miss;

   logic [1:0]  w_slot;
   logic [2:0]  w_s;
   logic [5:0]  w_fetch;
   logic [7:0]  w_ya;
   logic [7:0]  w_yb;
   logic [4:0]  w_row;
   logic [5:0]  w_col;
   logic [2:0]  w_fine;
   logic        w_ack_ok;

   assign w_slot  = r_tick[4:3];
   assign w_s     = r_tick[2:0];
   assign w_fetch = r_group + 6'd1;
   assign w_ya    = r_vpos + r_sya;
   assign w_yb    = r_vpos + r_syb;

   // Address fields of the layer owning the current slot; the fetch runs one group ahead.
   always_comb begin
      w_row  = r_vpos[7:3];
      w_col  = w_fetch;
      w_fine = r_vpos[2:0];
      case (w_slot)
         2'd1: begin
            w_row  = w_ya[7:3];
            w_col  = w_fetch + r_sxa[8:3];
            w_fine = w_ya[2:0];
         end
         2'd2: begin
            w_row  = w_yb[7:3];
            w_col  = w_fetch + r_sxb[8:3];
            w_fine = w_yb[2:0];
         end
         default: ;
      endcase
   end

   assign w_ack_ok = (r_state == S_ROM_WAIT) && r_rom_req && rom_ack;

   always_comb begin
      w_state_next = r_state;
      w_tick_next  = r_tick;
      w_group_next = r_group;
      if (line_start) begin
         w_state_next = S_MAP_RD;
         w_tick_next  = 5'd0;
         w_group_next = 6'd0;
      end else if (r_state != S_IDLE) begin
         if (r_tick == LAST_TICK) begin
            w_tick_next  = 5'd0;
            w_group_next = r_group + 6'd1;
            w_state_next = (r_group == LAST_GROUP) ? S_IDLE : S_MAP_RD;
         end else begin
            w_tick_next = r_tick + 5'd1;
            if (w_tick_next[4:3] == 2'd3) begin
               w_state_next = S_GAP;
            end else begin
               case (w_tick_next[2:0])
                  3'd0:    w_state_next = S_MAP_RD;
                  3'd1:    w_state_next = S_MAP_LATCH;
                  3'd7:    w_state_next = S_PRESENT;
                  default: w_state_next = S_ROM_WAIT;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk_24M) begin
      if (RES) begin
         r_state    <= S_IDLE;
         r_tick     <= 5'd0;
         r_group    <= 6'd0;
         r_vpos     <= 8'd0;
         r_sxa      <= 9'd0;
         r_sxb      <= 9'd0;
         r_sya      <= 8'd0;
         r_syb      <= 8'd0;
         r_za       <= 3'd0;
         r_zb       <= 3'd0;
         r_rom_req  <= 1'b0;
         r_rom_addr <= 14'd0;
         r_hit      <= 1'b0;
         r_rom_buf  <= 32'd0;
         r_col_pend <= 8'd0;
         r_vc       <= 32'd0;
         r_col      <= 8'd0;
         r_vc_layer <= 2'd0;
         r_miss     <= 8'd0;
      end else begin
         r_state <= w_state_next;
         r_tick  <= w_tick_next;
         r_group <= w_group_next;
         if (line_start) begin
            // Abort any slot in flight; dropping rom_req un-acked is a cancel.
            r_vpos    <= vpos;
            r_sxa     <= scrollx_a;
            r_sxb     <= scrollx_b;
            r_sya     <= scrolly_a;
            r_syb     <= scrolly_b;
            r_za      <= scrollx_a[2:0];
            r_zb      <= scrollx_b[2:0];
            r_rom_req <= 1'b0;
            r_hit     <= 1'b0;
         end else begin
            case (r_state)
               S_MAP_LATCH: begin
                  r_rom_addr <= {map_data[10:0], w_fine ^ {3{map_data[11]}}};
                  r_col_pend <= {map_data[15:11], 3'b000};
                  r_rom_req  <= 1'b1;
                  r_hit      <= 1'b0;
               end
               S_ROM_WAIT: begin
                  if (w_ack_ok) begin
                     r_rom_buf <= rom_data;
                     r_hit     <= 1'b1;
                     r_rom_req <= 1'b0;
                  end
                  // Last wait tick: load the presentation registers so they appear with the strobe.
                  if (w_s == 3'd6) begin
                     r_vc       <= w_ack_ok ? rom_data : (r_hit ? r_rom_buf : MISS_FILL);
                     r_col      <= r_col_pend;
                     r_vc_layer <= w_slot;
                     if (!w_ack_ok && !r_hit && (r_miss != 8'hFF)) begin
                        r_miss <= r_miss + 8'd1;
                     end
                  end
               end
               S_PRESENT: r_rom_req <= 1'b0;
               default: ;
            endcase
         end
      end
   end

   assign map_rd   = (r_state == S_MAP_RD);
   assign map_addr = map_rd ? {w_slot, w_row, w_col} : 13'd0;
   assign rom_req  = r_rom_req;
   assign rom_addr = r_rom_addr;
   assign vc_valid = (r_state == S_PRESENT);
   assign VC       = r_vc;
   assign COL      = r_col;
   assign vc_layer = r_vc_layer;
   assign miss_cnt = r_miss;
   assign ZA1H     = r_za[0];
   assign ZA2H     = r_za[1];
   assign ZA4H     = r_za[2];
   assign ZB1H     = r_zb[0];
   assign ZB2H     = r_zb[1];
   assign ZB4H     = r_zb[2];

endmodule

// File: tb/tb_k051962_tile_fetcher.sv
// Directed bench for k051962_tile_fetcher: vector table per layer slot plus hand-written
// sequences for misses, full-line pulse count, mid-slot abort and reset interactions.
module tb_k051962_tile_fetcher;

   logic        clk_24M = 1'b0;
   logic        RES = 1'b0;
   logic        line_start = 1'b0;
   logic [7:0]  vpos = 8'd0;
   logic [8:0]  scrollx_a = 9'd0;
   logic [8:0]  scrollx_b = 9'd0;
   logic [7:0]  scrolly_a = 8'd0;
   logic [7:0]  scrolly_b = 8'd0;
   logic        map_rd;
   logic [12:0] map_addr;
   logic [15:0] map_data = 16'd0;
   logic        rom_req;
   logic [13:0] rom_addr;
   logic        rom_ack = 1'b0;
   logic [31:0] rom_data = 32'd0;
   logic [31:0] VC;
   logic [7:0]  COL;
   logic        vc_valid;
   logic [1:0]  vc_layer;
   logic        ZA1H, ZA2H, ZA4H, ZB1H, ZB2H, ZB4H;
   logic [7:0]  miss_cnt;

   k051962_tile_fetcher dut (
      .clk_24M   (clk_24M),
      .RES       (RES),
      .line_start(line_start),
      .vpos      (vpos),
      .scrollx_a (scrollx_a),
      .scrollx_b (scrollx_b),
      .scrolly_a (scrolly_a),
      .scrolly_b (scrolly_b),
      .map_rd    (map_rd),
      .map_addr  (map_addr),
      .map_data  (map_data),
      .rom_req   (rom_req),
      .rom_addr  (rom_addr),
      .rom_ack   (rom_ack),
      .rom_data  (rom_data),
      .VC        (VC),
      .COL       (COL),
      .vc_valid  (vc_valid),
      .vc_layer  (vc_layer),
      .ZA1H      (ZA1H),
      .ZA2H      (ZA2H),
      .ZA4H      (ZA4H),
      .ZB1H      (ZB1H),
      .ZB2H      (ZB2H),
      .ZB4H      (ZB4H),
      .miss_cnt  (miss_cnt)
   );

   always #5 clk_24M = ~clk_24M;

   typedef struct {
      logic [7:0]  vp;
      logic [8:0]  sxa;
      logic [8:0]  sxb;
      logic [7:0]  sya;
      logic [7:0]  syb;
      logic [15:0] md;
      logic [31:0] rd;
      int          ack;
      int          layer;
      logic [12:0] e_map;
      logic [13:0] e_rom;
      logic [31:0] e_vc;
      logic [7:0]  e_col;
      logic [5:0]  e_z;
   } vec_t;

   vec_t vecs[6];
   int   checks = 0;
   int   errors = 0;
   int   ack_s[3];
   int   tcur = 0;
   int   ncyc = 0;
   int   pulses;
   int   misplaced;
   int   extra;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
      end
   endtask

   // Advance to the sampling point of the next cycle; the ROM model acks at the chosen slot tick.
   task automatic sample();
      int sl;
      @(negedge clk_24M);
      tcur = ncyc;
      ncyc++;
      sl = (tcur % 32) / 8;
      rom_ack = rom_req && (sl < 3) && (ack_s[(sl < 3) ? sl : 0] == (tcur % 8));
   endtask

   task automatic start_line(input logic [7:0] vp, input logic [8:0] sa, input logic [8:0] sb,
                             input logic [7:0] ya, input logic [7:0] yb);
      vpos = vp; scrollx_a = sa; scrollx_b = sb; scrolly_a = ya; scrolly_b = yb;
      line_start = 1'b1;
      @(posedge clk_24M);
      #1;
      line_start = 1'b0;
      rom_ack = 1'b0;
      ncyc = 0;
   endtask

   task automatic do_reset();
      @(negedge clk_24M);
      RES = 1'b1;
      rom_ack = 1'b0;
      @(posedge clk_24M);
      @(negedge clk_24M);
      RES = 1'b0;
   endtask

   initial begin
      vecs[0] = '{8'h00, 9'h000, 9'h000, 8'h00, 8'h00, 16'h0005, 32'hA5A5_0F0F, 3, 0,
                  13'h0001, 14'h0028, 32'hA5A5_0F0F, 8'h00, 6'h00};
      vecs[1] = '{8'h05, 9'h1FB, 9'h000, 8'h0C, 8'h00, 16'h0005, 32'h1234_5678, 2, 1,
                  13'h0880, 14'h0029, 32'h1234_5678, 8'h00, 6'h03};
      vecs[2] = '{8'h02, 9'h000, 9'h000, 8'h00, 8'h00, 16'hF801, 32'hDEAD_BEEF, 6, 0,
                  13'h0001, 14'h000D, 32'hDEAD_BEEF, 8'hF8, 6'h00};
      vecs[3] = '{8'h10, 9'h000, 9'h015, 8'h00, 8'hF3, 16'h0A07, 32'h0F0F_00FF, 4, 2,
                  13'h1003, 14'h103C, 32'h0F0F_00FF, 8'h08, 6'h28};
      vecs[4] = '{8'hF8, 9'h008, 9'h000, 8'h10, 8'h00, 16'h0003, 32'h0000_FFFF, 5, 1,
                  13'h0842, 14'h0018, 32'h0000_FFFF, 8'h00, 6'h00};
      vecs[5] = '{8'h09, 9'h000, 9'h000, 8'h00, 8'h00, 16'h1000, 32'h7777_7777, 7, 0,
                  13'h0041, 14'h0001, 32'h0000_0000, 8'h10, 6'h00};
      ack_s[0] = -1; ack_s[1] = -1; ack_s[2] = -1;

      // Reset state and idle behaviour before any line_start
      do_reset();
      chk("reset_vc", VC, 32'd0);
      chk("reset_ctrl", 32'({map_rd, rom_req, vc_valid, vc_layer, COL}), 32'd0);
      chk("reset_addr", 32'({map_addr, rom_addr}), 32'd0);
      chk("reset_z_miss", 32'({ZB4H, ZB2H, ZB1H, ZA4H, ZA2H, ZA1H, miss_cnt}), 32'd0);
      extra = 0;
      repeat (6) begin
         sample();
         extra += int'(map_rd) + int'(rom_req) + int'(vc_valid);
      end
      chk("idle_no_activity", 32'(extra), 32'd0);

      for (int i = 0; i < 6; i++) begin
         int lyr;
         lyr = vecs[i].layer;
         map_data = vecs[i].md;
         rom_data = vecs[i].rd;
         ack_s[0] = vecs[i].ack; ack_s[1] = vecs[i].ack; ack_s[2] = vecs[i].ack;
         start_line(vecs[i].vp, vecs[i].sxa, vecs[i].sxb, vecs[i].sya, vecs[i].syb);
         pulses = 0; misplaced = 0;
         for (int c = 0; c < 32; c++) begin
            sample();
            if (vc_valid) begin
               pulses++;
               if ((tcur % 8) != 7) misplaced++;
            end
            if (tcur == 0)
               chk($sformatf("v%0d_z", i), 32'({ZB4H, ZB2H, ZB1H, ZA4H, ZA2H, ZA1H}), 32'(vecs[i].e_z));
            if (tcur == lyr * 8) begin
               chk($sformatf("v%0d_map_rd", i), 32'(map_rd), 32'd1);
               chk($sformatf("v%0d_map_addr", i), 32'(map_addr), 32'(vecs[i].e_map));
            end
            if (tcur == lyr * 8 + 2) begin
               chk($sformatf("v%0d_rom_req", i), 32'(rom_req), 32'd1);
               chk($sformatf("v%0d_rom_addr", i), 32'(rom_addr), 32'(vecs[i].e_rom));
            end
            if (tcur == lyr * 8 + 7) begin
               chk($sformatf("v%0d_vc_valid", i), 32'(vc_valid), 32'd1);
               chk($sformatf("v%0d_vc", i), VC, vecs[i].e_vc);
               chk($sformatf("v%0d_col", i), 32'(COL), 32'(vecs[i].e_col));
               chk($sformatf("v%0d_layer", i), 32'(vc_layer), 32'(lyr));
            end
         end
         chk($sformatf("v%0d_pulses", i), 32'(pulses), 32'd3);
         chk($sformatf("v%0d_misplaced", i), 32'(misplaced), 32'd0);
         $display("vector %0d layer %0d VC=%08h COL=%02h rom_addr=%04h", i, lyr, VC, COL, rom_addr);
      end

      // Slot B never acked: transparent row, request dropped after PRESENT, one miss
      do_reset();
      map_data = 16'h0002; rom_data = 32'h1111_2222;
      ack_s[0] = 3; ack_s[1] = 3; ack_s[2] = -1;
      start_line(8'h00, 9'h000, 9'h000, 8'h00, 8'h00);
      for (int c = 0; c < 25; c++) begin
         sample();
         if (tcur == 15) chk("missB_vc_A", VC, 32'h1111_2222);
         if (tcur == 22) chk("missB_req_held", 32'(rom_req), 32'd1);
         if (tcur == 23) begin
            chk("missB_valid", 32'(vc_valid), 32'd1);
            chk("missB_vc_fill", VC, 32'h0000_0000);
            chk("missB_layer", 32'(vc_layer), 32'd2);
         end
         if (tcur == 24) begin
            chk("missB_req_drop", 32'(rom_req), 32'd0);
            chk("missB_cnt", 32'(miss_cnt), 32'd1);
         end
      end
      $display("miss-in-B sequence VC=%08h miss_cnt=%0d", VC, miss_cnt);

      // Full lines without acks: 144 strobes per line, silence after, counter saturates
      do_reset();
      ack_s[0] = -1; ack_s[1] = -1; ack_s[2] = -1;
      start_line(8'h20, 9'h000, 9'h000, 8'h00, 8'h00);
      pulses = 0; extra = 0;
      for (int c = 0; c < 48 * 32; c++) begin
         sample();
         pulses += int'(vc_valid);
      end
      for (int c = 0; c < 64; c++) begin
         sample();
         extra += int'(vc_valid) + int'(map_rd);
      end
      chk("line_pulses", 32'(pulses), 32'd144);
      chk("line_quiet_after", 32'(extra), 32'd0);
      chk("line_miss_144", 32'(miss_cnt), 32'd144);
      $display("full line strobes=%0d miss_cnt=%0d", pulses, miss_cnt);
      for (int ln = 0; ln < 2; ln++) begin
         start_line(8'h21, 9'h000, 9'h000, 8'h00, 8'h00);
         repeat (48 * 32 + 4) sample();
      end
      chk("miss_saturate", 32'(miss_cnt), 32'd255);
      $display("after 432 misses miss_cnt=%0d", miss_cnt);

      // line_start at slot A s4 with a pending request
      map_data = 16'h0001; rom_data = 32'hCAFE_F00D;
      ack_s[0] = 2; ack_s[1] = -1; ack_s[2] = 2;
      start_line(8'h00, 9'h000, 9'h000, 8'h00, 8'h00);
      repeat (13) sample();
      chk("abort_pending", 32'(rom_req), 32'd1);
      start_line(8'h00, 9'h007, 9'h000, 8'h00, 8'h00);
      pulses = 0;
      for (int c = 0; c < 7; c++) begin
         sample();
         if (tcur == 0) begin
            chk("abort_req_drop", 32'(rom_req), 32'd0);
            chk("abort_z_resample", 32'({ZA4H, ZA2H, ZA1H}), 32'd7);
         end
         pulses += int'(vc_valid);
      end
      chk("abort_no_valid", 32'(pulses), 32'd0);
      sample();
      chk("abort_fix_valid", 32'(vc_valid), 32'd1);
      chk("abort_fix_layer", 32'(vc_layer), 32'd0);
      chk("abort_fix_vc", VC, 32'hCAFE_F00D);
      $display("abort sequence FIX VC=%08h", VC);

      // RES mid-request, then RES together with line_start
      start_line(8'h00, 9'h000, 9'h000, 8'h00, 8'h00);
      repeat (13) sample();
      RES = 1'b1;
      @(posedge clk_24M);
      #1;
      RES = 1'b0;
      chk("res_req_drop", 32'(rom_req), 32'd0);
      chk("res_vc_clear", VC, 32'd0);
      chk("res_miss_clear", 32'(miss_cnt), 32'd0);
      @(negedge clk_24M);
      RES = 1'b1;
      line_start = 1'b1;
      @(posedge clk_24M);
      #1;
      RES = 1'b0;
      line_start = 1'b0;
      extra = 0;
      repeat (10) begin
         sample();
         extra += int'(map_rd) + int'(rom_req) + int'(vc_valid);
      end
      chk("res_beats_line_start", 32'(extra), 32'd0);
      $display("reset sequences done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
